// File: rtl/lcd_reg_arbiter.sv
// lcd_reg_arbiter
//
// CPU-facing LCD control block. Holds the memory-mapped LCD registers
// (LCDC FF40, STAT FF41, SCY FF42, SCX FF43, LY FF44, LYC FF45, BGP FF47),
// raises the VBLANK and STAT interrupt requests, and tells the external bus
// muxing whether the CPU may currently touch VRAM / OAM given the PPU mode.
//
// Ports
//   cpu_clock    in   clock, all state changes on its rising edge
//   reset        in   synchronous, active-high
//   cpu_addr     in   [15:0] CPU bus address
//   cpu_wdata    in   [7:0]  CPU write data
//   cpu_wr       in   write strobe (one cycle per access)
//   cpu_rd       in   read strobe (one cycle per access)
//   reg_sel      out  address hits FF40-FF45 or FF47 (combinational)
//   reg_rdata    out  [7:0] registered read data, held until the next read
//   vram_cpu_en  out  CPU may access 8000-9FFF this cycle (combinational)
//   oam_cpu_en   out  CPU may access FE00-FE9F this cycle (combinational)
//   ppu_mode_in  in   [1:0] PPU mode: 0 HBLANK, 1 VBLANK, 2 OAM, 3 ACTIVE
//   ly_in        in   [8:0] PPU current line (0-153)
//   lcdc/scy/scx/lyc/bgp  out  [7:0] register values for the PPU
//   irq_vblank   out  one-cycle VBLANK request
//   irq_stat     out  one-cycle STAT request (rising edge of the STAT line)

module lcd_reg_arbiter #(
  parameter logic [7:0] LCDC_RESET = 8'h91,
  parameter logic [7:0] BGP_RESET  = 8'hFC
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic        reg_sel,
  output logic [7:0]  reg_rdata,
  output logic        vram_cpu_en,
  output logic        oam_cpu_en,
  input  logic [1:0]  ppu_mode_in,
  input  logic [8:0]  ly_in,
  output logic [7:0]  lcdc,
  output logic [7:0]  scy,
  output logic [7:0]  scx,
  output logic [7:0]  lyc,
  output logic [7:0]  bgp,
  output logic        irq_vblank,
  output logic        irq_stat
);

  // Registers
  logic [7:0] lcdc_q, lcdc_d;
  logic [7:0] scy_q, scy_d;
  logic [7:0] scx_q, scx_d;
  logic [7:0] lyc_q, lyc_d;
  logic [7:0] bgp_q, bgp_d;
  logic [3:0] stat_en_q, stat_en_d;   // STAT bits [6:3]
  logic [7:0] reg_rdata_q, reg_rdata_d;
  logic [1:0] mode_q, mode_prev_q;
  logic [7:0] ly_q;
  logic       stat_line_q;

  // Lines above 255 never occur; the top bit of ly_in carries no information.
  logic       ly_msb_unused;
  assign ly_msb_unused = ly_in[8];

  // Effective status: with the LCD off everything reads as line 0, mode 0.
  logic       lcd_on;
  logic [1:0] eff_mode;
  logic [7:0] eff_ly;
  logic       coincidence;
  logic [3:0] stat_src;
  logic [3:0] stat_hit;
  logic       stat_line;
  logic [7:0] stat_rd;

  assign lcd_on      = lcdc_q[7];
  assign eff_mode    = lcd_on ? mode_q : 2'd0;
  assign eff_ly      = lcd_on ? ly_q : 8'd0;
  assign coincidence = lcd_on && (ly_q == lyc_q);

  // Source order matches the enable bits: en3 HBLANK, en4 VBLANK, en5 OAM, en6 LYC.
  assign stat_src[0] = (eff_mode == 2'd0);
  assign stat_src[1] = (eff_mode == 2'd1);
  assign stat_src[2] = (eff_mode == 2'd2);
  assign stat_src[3] = coincidence;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stat_hit
      assign stat_hit[gi] = stat_en_q[gi] & stat_src[gi];
    end
  endgenerate

  // All sources are OR-ed into one line so that overlapping sources produce a
  // single request; the pulse comes only on the line's rising edge.
  assign stat_line = lcd_on && (|stat_hit);
  assign stat_rd   = {1'b1, stat_en_q, coincidence, eff_mode};

  assign irq_stat   = stat_line && !stat_line_q;
  assign irq_vblank = lcd_on && (mode_q == 2'd1) && (mode_prev_q != 2'd1);

  // Access arbitration; with the LCD off the CPU owns both memories.
  assign vram_cpu_en = !lcd_on || (mode_q != 2'd3);
  assign oam_cpu_en  = !lcd_on || (mode_q == 2'd0) || (mode_q == 2'd1);

  assign reg_sel = (cpu_addr[15:4] == 12'hFF4) &&
                   ((cpu_addr[3:0] <= 4'h5) || (cpu_addr[3:0] == 4'h7));

  // Register writes
  always_comb begin
    lcdc_d    = lcdc_q;
    scy_d     = scy_q;
    scx_d     = scx_q;
    lyc_d     = lyc_q;
    bgp_d     = bgp_q;
    stat_en_d = stat_en_q;
    if (cpu_wr) begin
      case (cpu_addr)
        16'hFF40: lcdc_d    = cpu_wdata;
        16'hFF41: stat_en_d = cpu_wdata[6:3];
        16'hFF42: scy_d     = cpu_wdata;
        16'hFF43: scx_d     = cpu_wdata;
        16'hFF45: lyc_d     = cpu_wdata;
        16'hFF47: bgp_d     = cpu_wdata;
        default:  ;  // LY is read-only, everything else is not ours
      endcase
    end
  end

  // Register reads; values are those before any same-cycle write.
  always_comb begin
    reg_rdata_d = reg_rdata_q;
    if (cpu_rd) begin
      case (cpu_addr)
        16'hFF40: reg_rdata_d = lcdc_q;
        16'hFF41: reg_rdata_d = stat_rd;
        16'hFF42: reg_rdata_d = scy_q;
        16'hFF43: reg_rdata_d = scx_q;
        16'hFF44: reg_rdata_d = eff_ly;
        16'hFF45: reg_rdata_d = lyc_q;
        16'hFF47: reg_rdata_d = bgp_q;
        default:  reg_rdata_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      lcdc_q      <= LCDC_RESET;
      scy_q       <= 8'h00;
      scx_q       <= 8'h00;
      lyc_q       <= 8'h00;
      bgp_q       <= BGP_RESET;
      stat_en_q   <= 4'h0;
      reg_rdata_q <= 8'h00;
      mode_q      <= 2'd0;
      mode_prev_q <= 2'd0;
      ly_q        <= 8'h00;
      stat_line_q <= 1'b0;
    end else begin
      lcdc_q      <= lcdc_d;
      scy_q       <= scy_d;
      scx_q       <= scx_d;
      lyc_q       <= lyc_d;
      bgp_q       <= bgp_d;
      stat_en_q   <= stat_en_d;
      reg_rdata_q <= reg_rdata_d;
      mode_q      <= ppu_mode_in;
      mode_prev_q <= mode_q;
      ly_q        <= ly_in[7:0];
      stat_line_q <= stat_line;
    end
  end

  assign reg_rdata = reg_rdata_q;
  assign lcdc      = lcdc_q;
  assign scy       = scy_q;
  assign scx       = scx_q;
  assign lyc       = lyc_q;
  assign bgp       = bgp_q;

endmodule

// File: tb/tb_lcd_reg_arbiter.sv
module tb_lcd_reg_arbiter;

  logic        cpu_clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        reg_sel;
  logic [7:0]  reg_rdata;
  logic        vram_cpu_en;
  logic        oam_cpu_en;
  logic [1:0]  ppu_mode_in = 2'd0;
  logic [8:0]  ly_in = 9'd0;
  logic [7:0]  lcdc, scy, scx, lyc, bgp;
  logic        irq_vblank;
  logic        irq_stat;

  lcd_reg_arbiter #(.LCDC_RESET(8'h91), .BGP_RESET(8'hFC)) dut (
    .cpu_clock  (cpu_clock),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .reg_sel    (reg_sel),
    .reg_rdata  (reg_rdata),
    .vram_cpu_en(vram_cpu_en),
    .oam_cpu_en (oam_cpu_en),
    .ppu_mode_in(ppu_mode_in),
    .ly_in      (ly_in),
    .lcdc       (lcdc),
    .scy        (scy),
    .scx        (scx),
    .lyc        (lyc),
    .bgp        (bgp),
    .irq_vblank (irq_vblank),
    .irq_stat   (irq_stat)
  );

  always #5 cpu_clock = ~cpu_clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_lcdc, m_scy, m_scx, m_lyc, m_bgp, m_rdata, m_ly;
  logic [3:0] m_en;
  logic [1:0] m_mode, m_mode_prev;
  logic       m_line_prev;
  bit         m_valid = 1'b0;

  function automatic bit m_on();
    return m_lcdc[7];
  endfunction

  function automatic logic [1:0] m_eff_mode();
    return m_on() ? m_mode : 2'd0;
  endfunction

  function automatic bit m_coin();
    return m_on() && (m_ly == m_lyc);
  endfunction

  // STAT line: any enabled source currently true while the LCD is on.
  function automatic bit m_line();
    bit active [4];
    active[0] = (m_eff_mode() == 2'd0);
    active[1] = (m_eff_mode() == 2'd1);
    active[2] = (m_eff_mode() == 2'd2);
    active[3] = m_coin();
    for (int i = 0; i < 4; i++)
      if (m_en[i] && active[i]) return m_on();
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] a);
    case (a)
      16'hFF40: return m_lcdc;
      16'hFF41: return {1'b1, m_en, m_coin(), m_eff_mode()};
      16'hFF42: return m_scy;
      16'hFF43: return m_scx;
      16'hFF44: return m_on() ? m_ly : 8'h00;
      16'hFF45: return m_lyc;
      16'hFF47: return m_bgp;
      default:  return 8'hFF;
    endcase
  endfunction

  function automatic bit m_sel(input logic [15:0] a);
    return ((a >= 16'hFF40) && (a <= 16'hFF45)) || (a == 16'hFF47);
  endfunction

  // ---------------- vector type ----------------
  localparam logic [2:0] C_RD  = 3'b001;  // check reg_rdata after the edge
  localparam logic [2:0] C_EN  = 3'b010;  // check vram/oam enables before the edge
  localparam logic [2:0] C_IRQ = 3'b100;  // check both irq outputs before the edge

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        wr;
    logic        rd;
    logic [1:0]  mode;
    logic [8:0]  ly;
    logic [2:0]  chk;
    logic [7:0]  e_rd;
    logic        e_is;
    logic        e_iv;
    logic        e_ve;
    logic        e_oe;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [15:0] addr, input logic [7:0] wd,
                              input logic wr, input logic rd, input logic [1:0] mode,
                              input logic [8:0] ly, input logic [2:0] chk, input logic [7:0] e_rd,
                              input logic e_is, input logic e_iv, input logic e_ve, input logic e_oe);
    vec_t v;
    v.rst = rst; v.addr = addr; v.wd = wd; v.wr = wr; v.rd = rd; v.mode = mode; v.ly = ly;
    v.chk = chk; v.e_rd = e_rd; v.e_is = e_is; v.e_iv = e_iv; v.e_ve = e_ve; v.e_oe = e_oe;
    return v;
  endfunction

  // One bus cycle: drive on the falling edge, check combinational outputs
  // before the rising edge, advance the model, check registered outputs after.
  task automatic tick(input vec_t v, input string tag);
    bit         new_line;
    logic [7:0] rd_val;
    @(negedge cpu_clock);
    reset = v.rst; cpu_addr = v.addr; cpu_wdata = v.wd; cpu_wr = v.wr; cpu_rd = v.rd;
    ppu_mode_in = v.mode; ly_in = v.ly;
    #1;
    if (v.rst || v.wr || v.rd)
      $display("%s rst=%0d addr=%h wr=%0d wd=%h rd=%0d mode=%0d ly=%0d", tag, v.rst, v.addr,
               v.wr, v.wd, v.rd, v.mode, v.ly);
    if (m_valid) begin
      check({tag, " reg_sel"},     16'(reg_sel),     16'(m_sel(v.addr)));
      check({tag, " vram_cpu_en"}, 16'(vram_cpu_en), 16'(!m_on() || m_mode != 2'd3));
      check({tag, " oam_cpu_en"},  16'(oam_cpu_en),  16'(!m_on() || m_mode < 2'd2));
      check({tag, " irq_stat"},    16'(irq_stat),    16'(m_line() && !m_line_prev));
      check({tag, " irq_vblank"},  16'(irq_vblank),
            16'(m_on() && m_mode == 2'd1 && m_mode_prev != 2'd1));
    end
    if (v.chk & C_EN) begin
      check({tag, " hand vram_cpu_en"}, 16'(vram_cpu_en), 16'(v.e_ve));
      check({tag, " hand oam_cpu_en"},  16'(oam_cpu_en),  16'(v.e_oe));
    end
    if (v.chk & C_IRQ) begin
      check({tag, " hand irq_stat"},   16'(irq_stat),   16'(v.e_is));
      check({tag, " hand irq_vblank"}, 16'(irq_vblank), 16'(v.e_iv));
    end
    @(posedge cpu_clock);
    #1;
    if (v.rst) begin
      m_lcdc = 8'h91; m_bgp = 8'hFC; m_scy = 8'h00; m_scx = 8'h00; m_lyc = 8'h00;
      m_en = 4'h0; m_rdata = 8'h00; m_mode = 2'd0; m_mode_prev = 2'd0; m_ly = 8'h00;
      m_line_prev = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      new_line = m_line();
      rd_val = m_read(v.addr);
      if (v.rd) m_rdata = rd_val;
      if (v.wr) begin
        case (v.addr)
          16'hFF40: m_lcdc = v.wd;
          16'hFF41: m_en = v.wd[6:3];
          16'hFF42: m_scy = v.wd;
          16'hFF43: m_scx = v.wd;
          16'hFF45: m_lyc = v.wd;
          16'hFF47: m_bgp = v.wd;
          default: ;
        endcase
      end
      m_line_prev = new_line;
      m_mode_prev = m_mode;
      m_mode = v.mode;
      m_ly = v.ly[7:0];
    end
    if (m_valid) begin
      check({tag, " reg_rdata"}, 16'(reg_rdata), 16'(m_rdata));
      check({tag, " lcdc"}, 16'(lcdc), 16'(m_lcdc));
      check({tag, " scy"},  16'(scy),  16'(m_scy));
      check({tag, " scx"},  16'(scx),  16'(m_scx));
      check({tag, " lyc"},  16'(lyc),  16'(m_lyc));
      check({tag, " bgp"},  16'(bgp),  16'(m_bgp));
    end
    if (v.chk & C_RD) check({tag, " hand reg_rdata"}, 16'(reg_rdata), 16'(v.e_rd));
  endtask

  localparam logic [15:0] IDLE = 16'h0000;
  localparam logic [2:0]  CI  = C_IRQ;
  localparam logic [2:0]  CRI = C_RD | C_IRQ;
  localparam logic [2:0]  CEI = C_EN | C_IRQ;

  vec_t vecs [33];

  initial begin
    // Hand-derived directed sequence (expected values worked out from the rules).
    //               rst addr      wd    wr rd md ly      chk        erd   is iv ve oe
    vecs[0]  = mk(0, 16'hFF40, 8'h00, 0, 1, 2, 9'h01, CRI | C_EN, 8'h91, 0, 0, 1, 1);
    vecs[1]  = mk(0, 16'hFF47, 8'h00, 0, 1, 2, 9'h01, CRI | C_EN, 8'hFC, 0, 0, 1, 0);
    vecs[2]  = mk(0, 16'hFF41, 8'h00, 0, 1, 2, 9'h01, CRI,        8'h82, 0, 0, 0, 0);
    vecs[3]  = mk(0, 16'hFF41, 8'hFF, 1, 0, 0, 9'h05, CI,         8'h00, 0, 0, 0, 0);
    vecs[4]  = mk(0, 16'hFF41, 8'h00, 0, 1, 0, 9'h05, CRI,        8'hF8, 1, 0, 0, 0);
    vecs[5]  = mk(0, 16'hFF44, 8'h12, 1, 0, 0, 9'h05, CI,         8'h00, 0, 0, 0, 0);
    vecs[6]  = mk(0, 16'hFF44, 8'h00, 0, 1, 0, 9'h05, CRI,        8'h05, 0, 0, 0, 0);
    vecs[7]  = mk(0, 16'hFF41, 8'h40, 1, 0, 0, 9'h0F, CI,         8'h00, 0, 0, 0, 0);
    vecs[8]  = mk(0, 16'hFF45, 8'h10, 1, 0, 0, 9'h0F, CI,         8'h00, 0, 0, 0, 0);
    vecs[9]  = mk(0, IDLE,     8'h00, 0, 0, 0, 9'h10, CI,         8'h00, 0, 0, 0, 0);
    vecs[10] = mk(0, IDLE,     8'h00, 0, 0, 0, 9'h10, CI,         8'h00, 1, 0, 0, 0);
    vecs[11] = mk(0, IDLE,     8'h00, 0, 0, 0, 9'h10, CI,         8'h00, 0, 0, 0, 0);
    vecs[12] = mk(0, IDLE,     8'h00, 0, 0, 0, 9'h10, CI,         8'h00, 0, 0, 0, 0);
    vecs[13] = mk(0, 16'hFF41, 8'h18, 1, 0, 0, 9'h10, CI,         8'h00, 0, 0, 0, 0);
    vecs[14] = mk(0, IDLE,     8'h00, 0, 0, 0, 9'h20, CI,         8'h00, 0, 0, 0, 0);
    vecs[15] = mk(0, IDLE,     8'h00, 0, 0, 1, 9'h20, CI,         8'h00, 0, 0, 0, 0);
    vecs[16] = mk(0, IDLE,     8'h00, 0, 0, 1, 9'h20, CI,         8'h00, 0, 1, 0, 0);
    vecs[17] = mk(0, IDLE,     8'h00, 0, 0, 2, 9'h20, CI,         8'h00, 0, 0, 0, 0);
    vecs[18] = mk(0, IDLE,     8'h00, 0, 0, 0, 9'h20, CI,         8'h00, 0, 0, 0, 0);
    vecs[19] = mk(0, IDLE,     8'h00, 0, 0, 0, 9'h20, CI,         8'h00, 1, 0, 0, 0);
    vecs[20] = mk(0, IDLE,     8'h00, 0, 0, 0, 9'h20, CI,         8'h00, 0, 0, 0, 0);
    vecs[21] = mk(0, IDLE,     8'h00, 0, 0, 3, 9'h20, CI,         8'h00, 0, 0, 0, 0);
    vecs[22] = mk(0, IDLE,     8'h00, 0, 0, 3, 9'h20, CEI,        8'h00, 0, 0, 0, 0);
    vecs[23] = mk(0, IDLE,     8'h00, 0, 0, 2, 9'h20, CEI,        8'h00, 0, 0, 0, 0);
    vecs[24] = mk(0, IDLE,     8'h00, 0, 0, 2, 9'h20, CEI,        8'h00, 0, 0, 1, 0);
    vecs[25] = mk(0, 16'hFF40, 8'h11, 1, 0, 2, 9'h20, CEI,        8'h00, 0, 0, 1, 0);
    vecs[26] = mk(0, 16'hFF44, 8'h00, 0, 1, 2, 9'h20, CRI | C_EN, 8'h00, 0, 0, 1, 1);
    vecs[27] = mk(0, 16'hFF41, 8'h00, 0, 1, 2, 9'h20, CRI,        8'h98, 0, 0, 0, 0);
    vecs[28] = mk(0, 16'hFF40, 8'h91, 1, 0, 2, 9'h22, CI,         8'h00, 0, 0, 0, 0);
    vecs[29] = mk(0, 16'hFF41, 8'h40, 1, 0, 2, 9'h22, CI,         8'h00, 0, 0, 0, 0);
    vecs[30] = mk(0, 16'hFF45, 8'h22, 1, 0, 2, 9'h22, CI,         8'h00, 0, 0, 0, 0);
    vecs[31] = mk(1, IDLE,     8'h00, 0, 0, 2, 9'h22, CRI,        8'h00, 1, 0, 0, 0);
    vecs[32] = mk(0, IDLE,     8'h00, 0, 0, 0, 9'h00, CRI | C_EN, 8'h00, 0, 0, 1, 1);

    // Reset with the PPU already in mode 2 on line 1.
    tick(mk(1, IDLE, 8'h00, 0, 0, 2, 9'h01, 3'b000, 8'h00, 0, 0, 0, 0), "reset0");
    tick(mk(1, IDLE, 8'h00, 0, 0, 2, 9'h01, CRI | C_EN, 8'h00, 0, 0, 1, 1), "reset1");
    check("reset lcdc", 16'(lcdc), 16'h0091);
    check("reset bgp",  16'(bgp),  16'h00FC);
    check("reset scy|scx|lyc", 16'(scy | scx | lyc), 16'h0000);

    for (int i = 0; i < 33; i++) tick(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted during the irq_stat pulse cycle must leave reset values.
    check("post-pulse-reset lcdc", 16'(lcdc), 16'h0091);
    check("post-pulse-reset bgp",  16'(bgp),  16'h00FC);
    check("post-pulse-reset lyc",  16'(lyc),  16'h0000);

    // Randomized traffic against the model.
    begin
      logic [1:0]  mode = 2'd0;
      logic [8:0]  ly = 9'd0;
      for (int n = 0; n < 3000; n++) begin
        vec_t        v;
        logic [31:0] rv;
        int          sel;
        rv  = $urandom();
        sel = $urandom_range(0, 9);
        if (sel < 8)       v.addr = 16'hFF40 + 16'(sel);
        else if (sel == 8) v.addr = 16'h8000 | {3'b000, rv[12:0]};
        else               v.addr = rv[15:0];
        v.wd = rv[23:16];
        v.wr = ($urandom_range(0, 3) == 0);
        v.rd = ($urandom_range(0, 2) == 0);
        if (v.wr && v.addr == 16'hFF40) v.wd[7] = ($urandom_range(0, 3) != 0);
        if (v.wr && v.addr == 16'hFF45 && rv[24]) v.wd = ly[7:0];
        if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0:       ly = 9'h10;
            1:       ly = 9'h22;
            default: ly = 9'($urandom_range(0, 153));
          endcase
        end
        v.mode = mode;
        v.ly   = ly;
        v.rst  = ($urandom_range(0, 499) == 0);
        v.chk  = 3'b000;
        v.e_rd = 8'h00; v.e_is = 1'b0; v.e_iv = 1'b0; v.e_ve = 1'b0; v.e_oe = 1'b0;
        tick(v, $sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
